// File: rtl/seq_alu_result_checker_pkg.sv
// rtl/seq_alu_result_checker_pkg.sv - shared opcode type, limits and ALU reference function
package seq_alu_result_checker_pkg;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        AND = 2'd2,
        OR  = 2'd3
    } opcode_t;

    localparam int MAX_LATENCY = 8;
    // Widest operand the reference function handles; callers sign-extend into it
    localparam int MAX_WIDTH   = 32;

    // Operands arrive already sign-extended, so the low WIDTH+1 bits of the
    // result equal the WIDTH+1-bit ALU result for any WIDTH <= MAX_WIDTH.
    function automatic logic signed [MAX_WIDTH:0] alu_ref(
        input opcode_t                   op,
        input logic signed [MAX_WIDTH:0] a,
        input logic signed [MAX_WIDTH:0] b
    );
        logic signed [MAX_WIDTH:0] r;
        case (op)
            ADD:     r = a + b;
            SUB:     r = a - b;
            AND:     r = a & b;
            default: r = a | b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_alu_result_checker_sat_counter.sv
// rtl/seq_alu_result_checker_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Clear wins over increment; the count sticks at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/seq_alu_result_checker.sv
// rtl/seq_alu_result_checker.sv - latency-matched golden model and result checker for the sequential ALU (optional SEQ_ALU_CHK_FIRST_ERR_EN)
module seq_alu_result_checker
    import seq_alu_result_checker_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  opcode_t                 opcode,
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    input  logic signed [WIDTH:0]   C,
    input  logic                    chk_en,
    input  logic                    clr,
    output logic signed [WIDTH:0]   exp_result,
    output logic                    mismatch,
    output logic                    err_flag,
    output logic [CNT_W-1:0]        correct_count,
    output logic [CNT_W-1:0]        error_count,
    output logic [CNT_W-1:0]        first_err_cyc,
    output logic signed [WIDTH:0]   first_err_exp,
    output logic signed [WIDTH:0]   first_err_act
);

    if (LATENCY < 1 || LATENCY > MAX_LATENCY || WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_param_check
        $fatal(1, "seq_alu_result_checker: LATENCY must be 1..%0d and WIDTH 1..%0d", MAX_LATENCY, MAX_WIDTH);
    end

    logic signed [WIDTH:0] exp_q [LATENCY];
    logic signed [WIDTH:0] model_next;
    logic                  hit;
    logic                  count_hit;
    logic                  count_miss;

    assign model_next = (WIDTH+1)'(alu_ref(opcode, (MAX_WIDTH+1)'(A), (MAX_WIDTH+1)'(B)));

    // Stage 0 follows the DUT's enable; later stages are a plain shift matching its pipeline
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                exp_q[i] <= '0;
            end
        end else begin
            if (en) begin
                exp_q[0] <= model_next;
            end
            for (int i = 1; i < LATENCY; i++) begin
                exp_q[i] <= exp_q[i-1];
            end
        end
    end

    assign exp_result = exp_q[LATENCY-1];
    assign hit        = (C == exp_result);
    assign count_hit  = chk_en && !clr && hit;
    assign count_miss = chk_en && !clr && !hit;

    sat_counter #(.W(CNT_W)) u_correct_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (count_hit),
        .clr   (clr),
        .count (correct_count)
    );

    sat_counter #(.W(CNT_W)) u_error_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (count_miss),
        .clr   (clr),
        .count (error_count)
    );

    // One-cycle mismatch pulse and sticky error flag, both wiped by clr
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mismatch <= 1'b0;
            err_flag <= 1'b0;
        end else if (clr) begin
            mismatch <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            mismatch <= count_miss;
            if (count_miss) begin
                err_flag <= 1'b1;
            end
        end
    end

`ifdef SEQ_ALU_CHK_FIRST_ERR_EN
    logic [CNT_W-1:0] cyc_cnt;

    sat_counter #(.W(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .clr   (clr),
        .count (cyc_cnt)
    );

    // err_flag still low means no counted mismatch yet, so this is the first one to capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_err_cyc <= '0;
            first_err_exp <= '0;
            first_err_act <= '0;
        end else if (clr) begin
            first_err_cyc <= '0;
            first_err_exp <= '0;
            first_err_act <= '0;
        end else if (count_miss && !err_flag) begin
            first_err_cyc <= cyc_cnt;
            first_err_exp <= exp_result;
            first_err_act <= C;
        end
    end
`else
    assign first_err_cyc = '0;
    assign first_err_exp = '0;
    assign first_err_act = '0;
`endif

endmodule

// File: tb/tb_seq_alu_result_checker.sv
// tb/tb_seq_alu_result_checker.sv - scoreboard bench for seq_alu_result_checker
module tb_seq_alu_result_checker;
    import seq_alu_result_checker_pkg::*;

    localparam int WIDTH   = 4;
    localparam int LATENCY = 3;
    localparam int CNT_W   = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int C_OK    = 1000;
    localparam int C_BAD   = 1001;

    typedef struct {
        int exp_res;
        int mis;
        int flag;
        int cc;
        int ec;
        int fcyc;
        int fexp;
        int fact;
    } exp_t;

    exp_t sbq[$];

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en;
    opcode_t               opcode;
    logic signed [WIDTH-1:0] A;
    logic signed [WIDTH-1:0] B;
    logic signed [WIDTH:0] C;
    logic                  chk_en;
    logic                  clr;
    logic signed [WIDTH:0] exp_result;
    logic                  mismatch;
    logic                  err_flag;
    logic [CNT_W-1:0]      correct_count;
    logic [CNT_W-1:0]      error_count;
    logic [CNT_W-1:0]      first_err_cyc;
    logic signed [WIDTH:0] first_err_exp;
    logic signed [WIDTH:0] first_err_act;

    int errors = 0;
    int checks = 0;

    // reference model state
    int hist[$];
    int m_cc, m_ec, m_flag, m_mis, m_cyc, m_fcyc, m_fexp, m_fact;

    seq_alu_result_checker #(.WIDTH(WIDTH), .LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .opcode        (opcode),
        .A             (A),
        .B             (B),
        .C             (C),
        .chk_en        (chk_en),
        .clr           (clr),
        .exp_result    (exp_result),
        .mismatch      (mismatch),
        .err_flag      (err_flag),
        .correct_count (correct_count),
        .error_count   (error_count),
        .first_err_cyc (first_err_cyc),
        .first_err_exp (first_err_exp),
        .first_err_act (first_err_act)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int alu(input int op, input int a, input int b);
        case (op)
            0:       return a + b;
            1:       return a - b;
            2:       return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic int inc_sat(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    function automatic void model_reset();
        m_cc = 0; m_ec = 0; m_flag = 0; m_mis = 0; m_cyc = 0;
        m_fcyc = 0; m_fexp = 0; m_fact = 0;
        hist.delete();
        repeat (LATENCY) hist.push_back(0);
    endfunction

    // Drive one cycle of inputs at negedge and queue the outputs expected after the next posedge
    task automatic drive(input bit r, input bit e, input int op, input int a, input int b,
                         input int cv, input bit ck, input bit cl);
        exp_t x;
        int   ev;
        int   cval;
        int   nv;
        @(negedge clk);
        ev   = hist[0];
        cval = (cv == C_OK) ? ev : (cv == C_BAD) ? (ev ^ 1) : cv;
        rst    = r;
        en     = e;
        opcode = opcode_t'(op);
        A      = WIDTH'(a);
        B      = WIDTH'(b);
        C      = (WIDTH+1)'(cval);
        chk_en = ck;
        clr    = cl;
        if (!r) begin
            model_reset();
        end else begin
            if (cl) begin
                m_cc = 0; m_ec = 0; m_flag = 0; m_mis = 0; m_cyc = 0;
                m_fcyc = 0; m_fexp = 0; m_fact = 0;
            end else begin
                m_mis = 0;
                if (ck) begin
                    if (cval == ev) begin
                        m_cc = inc_sat(m_cc);
                    end else begin
                        m_ec  = inc_sat(m_ec);
                        m_mis = 1;
                        if (m_flag == 0) begin
                            m_fcyc = m_cyc; m_fexp = ev; m_fact = cval;
                        end
                        m_flag = 1;
                    end
                end
                m_cyc = inc_sat(m_cyc);
            end
            nv = e ? alu(op, a, b) : hist[$];
            void'(hist.pop_front());
            hist.push_back(nv);
        end
        x.exp_res = hist[0];
        x.mis  = m_mis;
        x.flag = m_flag;
        x.cc   = m_cc;
        x.ec   = m_ec;
`ifdef SEQ_ALU_CHK_FIRST_ERR_EN
        x.fcyc = m_fcyc; x.fexp = m_fexp; x.fact = m_fact;
`else
        x.fcyc = 0; x.fexp = 0; x.fact = 0;
`endif
        sbq.push_back(x);
    endtask

    // Monitor: one expectation per clock edge, compared just after the edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("exp_result",    int'(exp_result),    e.exp_res);
            check("mismatch",      int'(mismatch),      e.mis);
            check("err_flag",      int'(err_flag),      e.flag);
            check("correct_count", int'(correct_count), e.cc);
            check("error_count",   int'(error_count),   e.ec);
            check("first_err_cyc", int'(first_err_cyc), e.fcyc);
            check("first_err_exp", int'(first_err_exp), e.fexp);
            check("first_err_act", int'(first_err_act), e.fact);
        end
    end

    initial begin
        int wait_cnt;
        rst = 1'b0; en = 1'b0; opcode = ADD; A = '0; B = '0; C = '0;
        chk_en = 1'b1; clr = 1'b0;
        model_reset();

        // T1: held in reset, then idle compares count as hits
        repeat (3) drive(0, 0, 0, 0, 0, 0, 1, 0);
        repeat (4) drive(1, 0, 0, 0, 0, C_OK, 1, 0);

        // T2: the four operations including the -8-7 extreme
        drive(1, 0, 0, 0, 0, C_OK, 1, 1);
        drive(1, 1, 0,  7,  1, C_OK, 1, 0);
        drive(1, 1, 1, -8,  7, C_OK, 1, 0);
        drive(1, 1, 2,  5,  3, C_OK, 1, 0);
        drive(1, 1, 3,  5,  2, C_OK, 1, 0);
        repeat (LATENCY + 1) drive(1, 0, 0, 0, 0, C_OK, 1, 0);

        // T3: correct value presented one edge early
        drive(1, 0, 0, 0, 0, C_OK, 1, 1);
        drive(1, 1, 0, 2, 3, C_OK, 1, 0);
        drive(1, 0, 0, 0, 0, C_OK, 1, 0);
        drive(1, 0, 0, 0, 0, 5, 1, 0);
        drive(1, 0, 0, 0, 0, 5, 1, 0);
        drive(1, 0, 0, 0, 0, C_OK, 1, 0);

        // T4: error counter saturation, then clr beats a same-cycle mismatch
        repeat (20) drive(1, 0, 0, 0, 0, C_BAD, 1, 0);
        drive(1, 0, 0, 0, 0, C_BAD, 1, 1);
        drive(1, 0, 0, 0, 0, C_OK, 1, 0);

        // T5: compares suppressed while the model keeps tracking en
        for (int i = 0; i < 10; i++) begin
            drive(1, 1'(i % 2), i % 4, i - 5, 3 - i, C_BAD, 0, 0);
        end
        drive(1, 0, 0, 0, 0, C_OK, 1, 0);

        // T6: first-error capture at cycle 12 (exp 5, act 4), second error at 20
        drive(1, 1, 0, 2, 3, C_OK, 1, 0);
        drive(1, 0, 0, 0, 0, C_OK, 1, 1);
        for (int i = 0; i < 25; i++) begin
            drive(1, 0, 0, 0, 0, (i == 12 || i == 20) ? C_BAD : C_OK, 1, 0);
        end

        // Random phase with occasional clr and mid-run reset
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 99) != 0,
                  1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 15)) - 8,
                  int'($urandom_range(0, 15)) - 8,
                  ($urandom_range(0, 4) == 0) ? C_BAD : C_OK,
                  $urandom_range(0, 7) != 0,
                  $urandom_range(0, 29) == 0);
        end

        wait_cnt = 0;
        while (sbq.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        checks++;
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
